traffic_signal_controller: RTL and testbench



---
 rtl/traffic_signal_controller.sv | 62 ++++++
 tb/tb_traffic_signal_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/traffic_signal_controller.sv
// traffic_signal_controller: Moore FSM for a highway/country-road intersection.
// Highway is green by default; a country car triggers a timed handover through all-red.
module traffic_signal_controller #(
  parameter int Y2R_DELAY = 3,
  parameter int R2G_DELAY = 2,
  parameter int TIMER_W   = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       x,
  output logic [1:0] hwy,
  output logic [1:0] cntry
);
  localparam logic [2:0] S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4;
  localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2;
  logic [2:0]         r_state, w_next;
  logic [TIMER_W-1:0] r_timer;
  logic               w_y_done, w_r_done, w_untimed;
  assign w_y_done  = r_timer == TIMER_W'(Y2R_DELAY - 1);
  assign w_r_done  = r_timer == TIMER_W'(R2G_DELAY - 1);
  assign w_untimed = r_state == S0 || r_state == S3;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      r_state <= S0;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= (w_next != r_state || w_untimed) ? '0 : r_timer + 1'b1;
    end
  // Unreachable codes fall through to S0 on the next edge.
  always_comb begin
    w_next = S0;
    case (r_state)
      S0: w_next = x ? S1 : S0;
      S1: w_next = w_y_done ? S2 : S1;
      S2: w_next = w_r_done ? S3 : S2;
      S3: w_next = x ? S3 : S4;
      S4: w_next = w_y_done ? S0 : S4;
      default: w_next = S0;
    endcase
  end
  always_comb begin
    hwy   = GREEN;
    cntry = RED;
    case (r_state)
      S1: hwy = YELLOW;
      S2: hwy = RED;
      S3: begin
        hwy   = RED;
        cntry = GREEN;
      end
      S4: begin
        hwy   = RED;
        cntry = YELLOW;
      end
      default: begin
        hwy   = GREEN;
        cntry = RED;
      end
    endcase
  end
endmodule

// File: tb/tb_traffic_signal_controller.sv
// tb_traffic_signal_controller: directed checks of the intersection controller
// with defaults Y2R_DELAY=3, R2G_DELAY=2.
module tb_traffic_signal_controller;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       x   = 1'b0;
  logic [1:0] hwy, cntry;
  int         n_vec = 0;
  int         n_err = 0;

  traffic_signal_controller #(.Y2R_DELAY(3), .R2G_DELAY(2), .TIMER_W(8)) dut (
    .clk(clk), .clr(clr), .x(x), .hwy(hwy), .cntry(cntry)
  );

  always #5 clk = ~clk;

  // Advance one clock, sample 1 time unit after the edge, and check the safety invariant.
  task automatic tick();
    @(posedge clk);
    #1;
    n_vec++;
    if (hwy === 2'd3 || cntry === 2'd3 || (hwy !== 2'd0 && cntry !== 2'd0)) begin
      n_err++;
      $display("FAIL safety at %0t: hwy=%0d cntry=%0d, need one side RED and no code 3", $time, hwy, cntry);
    end
  endtask

  task automatic test_reset();
    #3;
    clr = 1'b0;
    x   = 1'b1;
    #1;
    n_vec++;
    if (hwy !== 2'd2 || cntry !== 2'd0) begin
      n_err++;
      $display("FAIL reset_async: hwy=%0d cntry=%0d, expected 2/0", hwy, cntry);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (hwy !== 2'd2 || cntry !== 2'd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: hwy=%0d cntry=%0d, expected 2/0", i, hwy, cntry);
      end
    end
  endtask

  task automatic test_idle();
    x   = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (hwy !== 2'd2 || cntry !== 2'd0) begin
        n_err++;
        $display("FAIL idle[%0d]: hwy=%0d cntry=%0d, expected 2/0", i, hwy, cntry);
      end
    end
  endtask

  // Starts in S0; x toggles in S1/S2 when noisy=1, which must not change timing.
  task automatic test_handover(input bit noisy);
    logic [1:0] eh, ec;
    x = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (noisy) x = ~x;
      eh = (i < 3) ? 2'd1 : 2'd0;
      ec = (i < 5) ? 2'd0 : 2'd2;
      n_vec++;
      if (hwy !== eh || cntry !== ec) begin
        n_err++;
        $display("FAIL handover%0d[%0d]: hwy=%0d cntry=%0d, expected %0d/%0d", noisy, i, hwy, cntry, eh, ec);
      end
    end
  endtask

  task automatic test_hold_country();
    x = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (hwy !== 2'd0 || cntry !== 2'd2) begin
        n_err++;
        $display("FAIL hold_s3[%0d]: hwy=%0d cntry=%0d, expected 0/2", i, hwy, cntry);
      end
    end
  endtask

  // Leaves S3; with late_car=1 a car arrives during S4 and must wait for S0.
  task automatic test_return(input bit late_car);
    logic [1:0] eh, ec;
    x = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (late_car) x = 1'b1;
      eh = (i < 3) ? 2'd0 : (late_car && i > 3) ? 2'd1 : 2'd2;
      ec = (i < 3) ? 2'd1 : 2'd0;
      n_vec++;
      if (hwy !== eh || cntry !== ec) begin
        n_err++;
        $display("FAIL return%0d[%0d]: hwy=%0d cntry=%0d, expected %0d/%0d", late_car, i, hwy, cntry, eh, ec);
      end
    end
  endtask

  // Enters S2 or S4 from S0/S3, pulls clr mid-cycle, then checks a clean restart.
  task automatic test_mid_reset(input bit in_s4);
    logic [1:0] eh;
    if (in_s4) begin
      x = 1'b1;
      repeat (6) tick();
      x = 1'b0;
      repeat (2) tick();
    end else begin
      x = 1'b1;
      repeat (4) tick();
    end
    n_vec++;
    if (hwy !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset%0d_setup: hwy=%0d, expected 0", in_s4, hwy);
    end
    #2;
    clr = 1'b0;
    #1;
    n_vec++;
    if (hwy !== 2'd2 || cntry !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset%0d_async: hwy=%0d cntry=%0d, expected 2/0", in_s4, hwy, cntry);
    end
    x = 1'b1;
    tick();
    clr = 1'b1;
    x   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (hwy !== 2'd2 || cntry !== 2'd0) begin
        n_err++;
        $display("FAIL mid_reset%0d_wait[%0d]: hwy=%0d cntry=%0d, expected 2/0", in_s4, i, hwy, cntry);
      end
    end
    x = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      eh = (i < 3) ? 2'd1 : 2'd0;
      n_vec++;
      if (hwy !== eh || cntry !== 2'd0) begin
        n_err++;
        $display("FAIL mid_reset%0d_restart[%0d]: hwy=%0d cntry=%0d, expected %0d/0", in_s4, i, hwy, cntry, eh);
      end
    end
    x = 1'b0;
    repeat (2) tick();
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_handover(1'b0);
    test_hold_country();
    test_return(1'b0);
    test_handover(1'b1);
    test_return(1'b1);
    repeat (6) tick();
    x = 1'b0;
    tick();
    repeat (4) tick();
    test_mid_reset(1'b0);
    test_mid_reset(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
